// File: rtl/sc_spi_xfer_seq.sv
// SPI transfer sequencer: chip-select setup/hold/idle timing around an N-byte MSB-first
// shift, clocked by an external SPICLK generator (sc_spi_scg) that this block enables.
module sc_spi_xfer_seq #(
    parameter int unsigned CSS_CYC = 2,
    parameter int unsigned CSH_CYC = 2,
    parameter int unsigned CSI_CYC = 4
) (
    input  logic       SRCCLK,
    input  logic       SYSRSTB,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [7:0] CMD_LEN,
    input  logic [7:0] CMD_CLKDR,
    input  logic [1:0] CMD_MODE,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic [7:0] TX_DATA,
    output logic       RX_VALID,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic [7:0] CLK_CLKDR,
    output logic [1:0] CLK_MODE,
    output logic       CLK_ENABLE,
    input  logic       SPICLK,
    output logic       SPI_CSB,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CSS_LAST = CNT_W'(CSS_CYC - 1);
    localparam logic [CNT_W-1:0] CSH_LAST = CNT_W'(CSH_CYC - 1);
    localparam logic [CNT_W-1:0] CSI_LAST = CNT_W'(CSI_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       bytes_q, bytes_d;
    logic [7:0]       txsh_q, txsh_d;
    logic [6:0]       rxsh_q, rxsh_d;
    logic [3:0]       smp_q, smp_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       clkdr_q, clkdr_d;
    logic [1:0]       mode_q, mode_d;
    logic             spiclk_q;
    logic             csb_q, csb_d;
    logic             clk_en_q, clk_en_d;
    logic             mosi_q, mosi_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ready;

    logic       cpha, lead, trail, sample_edge, shift_edge, byte_end, more_bytes;
    logic [7:0] ld_txsh;
    logic       ld_mosi;

    assign cpha        = mode_q[0];
    assign lead        = SPICLK & ~spiclk_q;
    assign trail       = ~SPICLK & spiclk_q;
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead : trail;
    // With CPHA=1 the 8th sample and the byte end are the same trail.
    assign byte_end    = trail & (cpha ? (smp_q == 4'd7) : (smp_q == 4'd8));
    assign more_bytes  = bytes_q > 9'd1;

    // CPHA=0 drives bit 7 at load; CPHA=1 leaves it for the first lead to present.
    assign ld_txsh = cpha ? TX_DATA : {TX_DATA[6:0], 1'b0};
    assign ld_mosi = cpha ? mosi_q : TX_DATA[7];

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge SRCCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bytes_q    <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            smp_q      <= '0;
            rx_data_q  <= '0;
            clkdr_q    <= 8'd2;
            mode_q     <= '0;
            spiclk_q   <= 1'b0;
            csb_q      <= 1'b1;
            clk_en_q   <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bytes_q    <= bytes_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            smp_q      <= smp_d;
            rx_data_q  <= rx_data_d;
            clkdr_q    <= clkdr_d;
            mode_q     <= mode_d;
            spiclk_q   <= SPICLK;
            csb_q      <= csb_d;
            clk_en_q   <= clk_en_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // NOTE: every signal written here gets its default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bytes_d    = bytes_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        smp_d      = smp_q;
        rx_data_d  = rx_data_q;
        clkdr_d    = clkdr_q;
        mode_d     = mode_q;
        csb_d      = csb_q;
        clk_en_d   = clk_en_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        tx_ready   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    bytes_d = {1'b0, CMD_LEN} + 9'd1;
                    clkdr_d = (CMD_CLKDR < 8'd2) ? 8'd2 : CMD_CLKDR;
                    mode_d  = CMD_MODE;
                    csb_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CSS_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOAD: begin
                tx_ready = 1'b1;
                clk_en_d = 1'b0;
                if (TX_VALID) begin
                    txsh_d   = ld_txsh;
                    mosi_d   = ld_mosi;
                    smp_d    = '0;
                    clk_en_d = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sample_edge) begin
                    smp_d  = smp_q + 4'd1;
                    rxsh_d = {rxsh_q[5:0], SPI_MISO};
                    if (smp_q == 4'd7) begin
                        rx_data_d  = {rxsh_q, SPI_MISO};
                        rx_valid_d = 1'b1;
                    end
                end
                if (shift_edge && !byte_end) begin
                    mosi_d = txsh_q[7];
                    txsh_d = {txsh_q[6:0], 1'b0};
                end
                if (byte_end) begin
                    bytes_d = bytes_q - 9'd1;
                    if (more_bytes) begin
                        tx_ready = 1'b1;
                        if (TX_VALID) begin
                            txsh_d = ld_txsh;
                            mosi_d = ld_mosi;
                            smp_d  = '0;
                        end else begin
                            clk_en_d = 1'b0;
                            state_d  = S_LOAD;
                        end
                    end else begin
                        clk_en_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == CSH_LAST) begin
                    csb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == CSI_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign CMD_READY  = (state_q == S_IDLE);
    assign BUSY       = (state_q != S_IDLE);
    assign TX_READY   = tx_ready;
    assign RX_VALID   = rx_valid_q;
    assign RX_DATA    = rx_data_q;
    assign CLK_CLKDR  = clkdr_q;
    assign CLK_MODE   = mode_q;
    assign CLK_ENABLE = clk_en_q;
    assign SPI_CSB    = csb_q;
    assign SPI_MOSI   = mosi_q;

endmodule
